hsv_color_filter_pipeline: RTL and testbench

- Streaming 8-bit RGB pixel pipeline in the AR pong camera path, between the camera/frame source and the VGA/frame sink.
- Performs an optional 3x3 box blur using line buffers, then a simplified HSV red-object threshold.
- Emits either pass-through, blurred, or binary-mask video, plus a 1-bit mask flag per pixel.
- One output pixel per accepted input pixel, at fixed latency.

---
 rtl/hsv_color_filter_pipeline.sv | 219 +++++++++++++++++++++
 tb/tb_hsv_color_filter_pipeline.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_color_filter_pipeline.sv
// hsv_color_filter_pipeline
// Three-stage streaming RGB filter for the AR pong camera path:
//   stage 1 : 3x3 window build from two line buffers
//   stage 2 : 3x3 box blur (sum of nine, divide by nine, truncating)
//   stage 3 : source select, simplified HSV red threshold, output mux
// valid_o is valid_i delayed by exactly three clocks in every mode.
// Optional build macro MASK_OVERLAY_EN: in mask modes, masked pixels show
// green and unmasked pixels pass the source pixel through, instead of the
// default white/black binary mask.
module hsv_color_filter_pipeline #(
  parameter int LINES       = 640,
  parameter int PIXEL_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PIXEL_DEPTH-1:0] raw_VGA_R,
  input  logic [PIXEL_DEPTH-1:0] raw_VGA_G,
  input  logic [PIXEL_DEPTH-1:0] raw_VGA_B,
  input  logic                   valid_i,
  input  logic [12:0]            row,
  input  logic [12:0]            col,
  input  logic [4:0]             thresh,
  input  logic [1:0]             mode,
  output logic                   out_image,
  output logic [PIXEL_DEPTH-1:0] VGA_R,
  output logic [PIXEL_DEPTH-1:0] VGA_G,
  output logic [PIXEL_DEPTH-1:0] VGA_B,
  output logic                   valid_o
);

  localparam int AW = (LINES > 1) ? $clog2(LINES) : 1;
  // Nine samples of PIXEL_DEPTH bits need four extra bits of headroom.
  localparam int SW = PIXEL_DEPTH + 4;
  localparam logic [PIXEL_DEPTH-1:0] MIN_BRIGHT = PIXEL_DEPTH'(64);

  // Channel index 2 = red, 1 = green, 0 = blue.
  typedef logic [2:0][PIXEL_DEPTH-1:0] rgb_t;
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam rgb_t RGB_BLACK = '0;
  localparam rgb_t RGB_WHITE = '1;
`ifdef MASK_OVERLAY_EN
  localparam rgb_t RGB_GREEN = {{PIXEL_DEPTH{1'b0}}, {PIXEL_DEPTH{1'b1}}, {PIXEL_DEPTH{1'b0}}};
`endif

  // ---------------------------------------------------------------------
  // Line buffers: lb1 holds the previous row, lb0 the row before that.
  // ---------------------------------------------------------------------
  rgb_t           pix_in;
  logic           col_in_range;
  logic [AW-1:0]  lb_addr;
  rgb_t           lb0 [LINES];
  rgb_t           lb1 [LINES];
  rgb_t           lb0_rd;
  rgb_t           lb1_rd;

  assign pix_in       = {raw_VGA_R, raw_VGA_G, raw_VGA_B};
  assign col_in_range = (col < 13'(LINES));
  // Out-of-range columns are don't-care; park the address so reads stay legal.
  assign lb_addr      = col_in_range ? col[AW-1:0] : '0;
  assign lb0_rd       = lb0[lb_addr];
  assign lb1_rd       = lb1[lb_addr];

  // Push the new pixel into lb1 and age the old lb1 entry into lb0.
  // NOTE: line buffer storage has no reset; stale contents only feed
  // interior pixels after a mid-frame reset, and a reset port would stop
  // the arrays mapping onto RAM.
  always_ff @(posedge clk) begin
    if (reset_n && valid_i && col_in_range) begin
      lb1[lb_addr] <= pix_in;
      lb0[lb_addr] <= lb1_rd;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: 3x3 window. win[r][c]: r=0 two rows back, r=2 current row;
  // c=2 is the newest column.
  // ---------------------------------------------------------------------
  rgb_t win [3][3];
  logic s1_valid;
  logic s1_border;
  rgb_t s1_raw;

  // Shift the window left and load the new right column on each accepted pixel.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_raw    <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb0_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= pix_in;
        s1_raw    <= pix_in;
        s1_border <= (row < 13'd2) || (col < 13'd2);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: box blur.
  // ---------------------------------------------------------------------
  logic [SW-1:0] win_sum [3];
  rgb_t          blur_c;

  // Sum the nine window samples per channel and divide by nine.
  // NOTE: every combinational output gets a value before any conditional
  // logic, so no path can leave a latch behind.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      win_sum[ch] = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_sum[ch] = win_sum[ch] + SW'(win[r][c][ch]);
        end
      end
      blur_c[ch] = PIXEL_DEPTH'(win_sum[ch] / SW'(9));
    end
  end

  logic s2_valid;
  logic s2_border;
  rgb_t s2_raw;
  rgb_t s2_blur;

  // Register the blur result; border windows blur to black.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_raw    <= '0;
      s2_blur   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_border <= s1_border;
        s2_raw    <= s1_raw;
        s2_blur   <= s1_border ? RGB_BLACK : blur_c;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: threshold and output select. mode/thresh are live here.
  // ---------------------------------------------------------------------
  rgb_t                   src;
  logic [PIXEL_DEPTH-1:0] ch_max;
  logic [PIXEL_DEPTH-1:0] ch_min;
  logic [PIXEL_DEPTH-1:0] delta;
  logic                   mask_c;
  rgb_t                   out_c;

  // Pick the source pixel, evaluate the red-object mask, and form the output.
  always_comb begin
    src    = mode[0] ? s2_blur : s2_raw;

    ch_max = src[CH_R];
    if (src[CH_G] > ch_max) ch_max = src[CH_G];
    if (src[CH_B] > ch_max) ch_max = src[CH_B];

    ch_min = src[CH_R];
    if (src[CH_G] < ch_min) ch_min = src[CH_G];
    if (src[CH_B] < ch_min) ch_min = src[CH_B];

    delta  = ch_max - ch_min;

    mask_c = (src[CH_R] >= src[CH_G]) &&
             (src[CH_R] >= src[CH_B]) &&
             (delta >= PIXEL_DEPTH'({thresh, 3'b000})) &&
             (ch_max >= MIN_BRIGHT);
    // A blurred border window carries no real neighbourhood; never flag it.
    if (mode[0] && s2_border) mask_c = 1'b0;

    if (!mode[1]) begin
      out_c = src;
    end else begin
`ifdef MASK_OVERLAY_EN
      out_c = mask_c ? RGB_GREEN : src;
`else
      out_c = mask_c ? RGB_WHITE : RGB_BLACK;
`endif
    end
  end

  // Output registers update only with a valid pixel and hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_o   <= 1'b0;
      out_image <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        out_image <= mask_c;
        VGA_R     <= out_c[CH_R];
        VGA_G     <= out_c[CH_G];
        VGA_B     <= out_c[CH_B];
      end
    end
  end

endmodule

// File: tb/tb_hsv_color_filter_pipeline.sv
// tb_hsv_color_filter_pipeline
// Self-checking bench: directed frames plus randomized frames with valid
// gaps, compared every cycle against a frame-memory reference model.
module tb_hsv_color_filter_pipeline;

  localparam int LINES = 640;
  localparam int ROWS  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  raw_VGA_R, raw_VGA_G, raw_VGA_B;
  logic        valid_i;
  logic [12:0] row, col;
  logic [4:0]  thresh;
  logic [1:0]  mode;
  logic        out_image;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        valid_o;

  hsv_color_filter_pipeline #(.LINES(LINES), .PIXEL_DEPTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_VGA_R (raw_VGA_R),
    .raw_VGA_G (raw_VGA_G),
    .raw_VGA_B (raw_VGA_B),
    .valid_i   (valid_i),
    .row       (row),
    .col       (col),
    .thresh    (thresh),
    .mode      (mode),
    .out_image (out_image),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .valid_o   (valid_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // fm holds the frame as scanned so far; a pixel's blur is the mean of the
  // 3x3 block ending at that pixel, taken straight from the frame picture.
  logic [23:0] fm [ROWS][LINES];

  typedef struct packed {
    logic        v;
    logic [24:0] px;   // {mask, R, G, B}
  } exp_t;

  exp_t        pipe [3];
  logic [24:0] hold;

  function automatic logic [24:0] ref_pixel(input int r, input int c, input logic [23:0] p,
                                            input logic [1:0] m, input logic [4:0] th);
    int br, bg, bb, sr, sg, sb, mx, mn;
    bit border, mask;
    logic [23:0] q, s, o;
    border = (r < 2) || (c < 2);
    br = 0; bg = 0; bb = 0;
    if (!border) begin
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = 0; dc < 3; dc++) begin
          q  = fm[r-dr][c-dc];
          br += int'(q[23:16]);
          bg += int'(q[15:8]);
          bb += int'(q[7:0]);
        end
      end
      br = br / 9; bg = bg / 9; bb = bb / 9;
    end
    if (m[0]) begin
      sr = br; sg = bg; sb = bb;
    end else begin
      sr = int'(p[23:16]); sg = int'(p[15:8]); sb = int'(p[7:0]);
    end
    mx = (sr > sg) ? sr : sg;  mx = (sb > mx) ? sb : mx;
    mn = (sr < sg) ? sr : sg;  mn = (sb < mn) ? sb : mn;
    mask = (sr >= sg) && (sr >= sb) && ((mx - mn) >= int'(th) * 8) && (mx >= 64);
    if (m[0] && border) mask = 1'b0;
    s = {8'(sr), 8'(sg), 8'(sb)};
    if (!m[1]) o = s;
`ifdef MASK_OVERLAY_EN
    else o = mask ? 24'h00FF00 : s;
`else
    else o = mask ? 24'hFFFFFF : 24'h000000;
`endif
    return {mask, o};
  endfunction

  // Track what the outputs must show after each edge.
  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < LINES; c++)
        fm[r][c] = '0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    hold = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        hold = '0;
      end else begin
        pipe[2]   = pipe[1];
        pipe[1]   = pipe[0];
        pipe[0].v = valid_i;
        pipe[0].px = '0;
        if (valid_i) begin
          fm[int'(row)][int'(col)] = {raw_VGA_R, raw_VGA_G, raw_VGA_B};
          pipe[0].px = ref_pixel(int'(row), int'(col), {raw_VGA_R, raw_VGA_G, raw_VGA_B},
                                 mode, thresh);
        end
        if (pipe[2].v) hold = pipe[2].px;
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("valid_o", {31'd0, valid_o}, {31'd0, pipe[2].v});
      check("pixel", {7'd0, out_image, VGA_R, VGA_G, VGA_B}, {7'd0, hold});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int r, input int c, input logic [23:0] p);
    @(posedge clk);
    #1;
    valid_i = v;
    row     = 13'(r);
    col     = 13'(c);
    {raw_VGA_R, raw_VGA_G, raw_VGA_B} = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 24'h0);
  endtask

  // Flush the pipe before changing controls so no pixel sees a mixed setting.
  task automatic set_mode(input logic [1:0] m, input logic [4:0] th);
    idle(4);
    mode   = m;
    thresh = th;
  endtask

  function automatic logic [23:0] rand_pix();
    logic [7:0] r, g, b;
    r = 8'($urandom_range(255));
    if ($urandom_range(1) == 1) begin
      g = 8'($urandom_range(int'(r)));
      b = 8'($urandom_range(int'(r)));
    end else begin
      g = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
    end
    return {r, g, b};
  endfunction

  task automatic frame(input int nrows, input bit rnd, input logic [23:0] base, input int gap_pct);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < LINES; c++) begin
        while (gap_pct > 0 && $urandom_range(99) < gap_pct)
          drive(1'b0, r, c, rand_pix());
        drive(1'b1, r, c, rnd ? rand_pix() : base);
      end
    end
  endtask

  initial begin
    // Reset held three edges with valid_i high; the held pixel is the first
    // one accepted after release.
    reset_n   = 1'b0;
    valid_i   = 1'b1;
    mode      = 2'b00;
    thresh    = 5'd0;
    row       = 13'd5;
    col       = 13'd7;
    {raw_VGA_R, raw_VGA_G, raw_VGA_B} = {8'd12, 8'd34, 8'd56};
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Raw pass-through.
    for (int i = 0; i < 20; i++) drive(1'b1, 5, 8 + i, rand_pix());

    // Blur of a uniform grey frame.
    set_mode(2'b01, 5'd0);
    frame(4, 1'b0, {8'd90, 8'd90, 8'd90}, 0);

    // Full pipeline, strong red passes, weak saturation fails.
    set_mode(2'b11, 5'd15);
    frame(3, 1'b0, {8'd200, 8'd40, 8'd40}, 0);
    frame(3, 1'b0, {8'd200, 8'd100, 8'd100}, 0);

    // Mask of raw: dark red rejected, bright red accepted even at the corner.
    set_mode(2'b10, 5'd15);
    drive(1'b1, 0, 0, {8'd60, 8'd0, 8'd0});
    drive(1'b1, 0, 0, {8'd130, 8'd5, 8'd5});
    drive(1'b1, 3, 9, {8'd130, 8'd5, 8'd5});
    drive(1'b1, 4, 10, {8'd63, 8'd0, 8'd0});
    drive(1'b1, 4, 11, {8'd64, 8'd0, 8'd0});
    for (int i = 0; i < 40; i++)
      drive(1'b1, $urandom_range(ROWS - 1), $urandom_range(LINES - 1), rand_pix());

    // Randomized frames with valid gaps, including across line ends.
    set_mode(2'b11, 5'($urandom_range(31)));
    frame(4, 1'b1, 24'h0, 30);
    set_mode(2'b01, 5'd0);
    frame(4, 1'b1, 24'h0, 25);
    set_mode(2'b00, 5'd0);
    frame(1, 1'b1, 24'h0, 40);

    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
